// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: word, RAM handshake state and arbiter state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } last_grant_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Signal bundle between the instruction/data requesters, the arbiter and the RAM.
interface memory_arbiter_if
  import cpu_types_pkg::*;
(
  input logic CLK
);
  logic      nRST;
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      memerr;

  modport arb (
    input  CLK, nRST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

  modport tb (
    input  CLK, iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, memerr,
    output nRST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-requester RAM arbiter (instruction / data) with grant watchdog.
// Define MEM_ARB_FAIR_EN to alternate sides on contention; otherwise data always wins.
//
// state  | meaning
// IDLE   | no grant; strobes low, both waits high
// IGRANT | RAM owned by instruction read
// DGRANT | RAM owned by data read or write
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      memerr
);

  localparam int unsigned    WD_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  arb_state_t      state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            d_req;
  logic            pick_d;
  logic            own_req;
  logic            granted;

  assign d_req = dREN | dWEN;

`ifdef MEM_ARB_FAIR_EN
  last_grant_t last_grant_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_grant_q <= LAST_I;
    end else if (!dwait) begin
      last_grant_q <= LAST_D;
    end else if (!iwait) begin
      last_grant_q <= LAST_I;
    end
  end

  assign pick_d = d_req && (!iREN || (last_grant_q == LAST_I));
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  assign granted = (state_q == IGRANT) || (state_q == DGRANT);
  assign own_req = (state_q == DGRANT) ? d_req : iREN;

  always_comb begin
    state_d  = state_q;
    wd_d     = wd_q;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    memerr   = 1'b0;

    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (pick_d) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end
      IGRANT: begin
        if (iREN) begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
        end
      end
      DGRANT: begin
        if (d_req) begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = ~dWEN;
        end
      end
      default: state_d = IDLE;
    endcase

    // A dropped request abandons the grant quietly; otherwise resolve the RAM handshake.
    if (granted) begin
      if (!own_req) begin
        state_d = IDLE;
      end else begin
        case (ramstate)
          ACCESS: begin
            state_d = IDLE;
            if (state_q == IGRANT) begin
              iwait = 1'b0;
              iload = ramload;
            end else begin
              dwait = 1'b0;
              dload = ramload;
            end
          end
          ERROR: begin
            memerr  = 1'b1;
            state_d = IDLE;
          end
          default: begin
            if (wd_q == WD_LAST) begin
              memerr  = 1'b1;
              state_d = IDLE;
            end else begin
              wd_d = wd_q + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: behavioural RAM, expected loads/writes queued at issue.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  typedef struct {
    word_t addr;
    word_t data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  memory_arbiter_if bus (.CLK(clk));

  memory_arbiter #(.TIMEOUT_CYC(64)) dut (
    .CLK      (clk),
    .nRST     (bus.nRST),
    .iREN     (bus.iREN),
    .iaddr    (bus.iaddr),
    .iwait    (bus.iwait),
    .iload    (bus.iload),
    .dREN     (bus.dREN),
    .dWEN     (bus.dWEN),
    .daddr    (bus.daddr),
    .dstore   (bus.dstore),
    .dwait    (bus.dwait),
    .dload    (bus.dload),
    .ramREN   (bus.ramREN),
    .ramWEN   (bus.ramWEN),
    .ramaddr  (bus.ramaddr),
    .ramstore (bus.ramstore),
    .ramload  (bus.ramload),
    .ramstate (bus.ramstate),
    .memerr   (bus.memerr)
  );

  int    checks = 0;
  int    failures = 0;
  word_t iq[$];
  word_t dq[$];
  wr_t   wq[$];
  bit    order[$];
  int    cyc = 0;
  int    i_cnt = 0, d_cnt = 0;
  int    last_i_cyc = 0, last_d_cyc = 0;
  int    merr_cnt = 0, merr_cyc = 0, exp_merr = 0;
  bit    i_done = 0, d_done = 0;
  int    gc = 0;
  int    ram_lat = 1;
  bit    ram_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic word_t ram_val(input word_t a);
    if (a == 32'h40) return 32'hDEAD_BEEF;
    return (a * 3) + 32'h1111_0000;
  endfunction

  task automatic issue_i(input word_t a);
    bus.iREN  = 1'b1;
    bus.iaddr = a;
    iq.push_back(ram_val(a));
  endtask

  task automatic issue_dr(input word_t a);
    bus.dREN  = 1'b1;
    bus.dWEN  = 1'b0;
    bus.daddr = a;
    dq.push_back(ram_val(a));
  endtask

  task automatic issue_dw(input word_t a, input word_t v, input logic with_ren);
    wr_t w;
    bus.dWEN   = 1'b1;
    bus.dREN   = with_ren;
    bus.daddr  = a;
    bus.dstore = v;
    dq.push_back(ram_val(a));
    w.addr = a;
    w.data = v;
    wq.push_back(w);
  endtask

  // Behavioural RAM: answers ACCESS on the ram_lat-th consecutive strobed cycle.
  task automatic ram_eval();
    wr_t w;
    #1;
    if (bus.ramREN || bus.ramWEN) begin
      gc++;
      bus.ramload = ram_val(bus.ramaddr);
      if (ram_err) begin
        bus.ramstate = ERROR;
      end else if (gc == ram_lat) begin
        bus.ramstate = ACCESS;
        if (bus.ramWEN) begin
          if (wq.size() == 0) begin
            chk("w_unexpected", 1, 0);
          end else begin
            w = wq.pop_front();
            chk("ramaddr_w", bus.ramaddr, w.addr);
            chk("ramstore_w", bus.ramstore, w.data);
            chk("ramren_w", {31'd0, bus.ramREN}, 0);
          end
        end
      end else begin
        bus.ramstate = BUSY;
      end
    end else begin
      gc = 0;
      bus.ramstate = FREE;
      bus.ramload  = 32'hFFFF_FFFF;
    end
  endtask

  task automatic monitor();
    cyc++;
    if (!bus.iwait) begin
      i_cnt++; i_done = 1; last_i_cyc = cyc; order.push_back(1'b0);
      if (iq.size() == 0) chk("i_unexpected", 1, 0);
      else chk("iload", bus.iload, iq.pop_front());
    end else begin
      chk("iload_hold0", bus.iload, 0);
    end
    if (!bus.dwait) begin
      d_cnt++; d_done = 1; last_d_cyc = cyc; order.push_back(1'b1);
      if (dq.size() == 0) chk("d_unexpected", 1, 0);
      else chk("dload", bus.dload, dq.pop_front());
    end else begin
      chk("dload_hold0", bus.dload, 0);
    end
    if (bus.memerr) begin
      merr_cnt++; merr_cyc = cyc;
    end
  endtask

  task automatic step();
    ram_eval();
    @(negedge clk);
    monitor();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    if (i_done) begin bus.iREN = 1'b0; i_done = 0; end
    if (d_done) begin bus.dREN = 1'b0; bus.dWEN = 1'b0; d_done = 0; end
  endtask

  task automatic cycle();
    step();
    adv();
  endtask

  task automatic wait_side(input bit side, input int budget, output int c_done);
    int start;
    start  = side ? d_cnt : i_cnt;
    c_done = -1;
    for (int n = 0; n < budget; n++) begin
      cycle();
      if ((side ? d_cnt : i_cnt) != start) begin
        c_done = side ? last_d_cyc : last_i_cyc;
        return;
      end
    end
    chk(side ? "d_wait_timeout" : "i_wait_timeout", 0, 1);
  endtask

  initial begin
    int c0, cd, ci, m0, k;
    bit found;
    int exp_ord[7];

    bus.nRST = 1'b1; bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.ramload = 32'hFFFF_FFFF; bus.ramstate = FREE;
    #2 bus.nRST = 1'b0;
    #1;
    chk("rst_iwait", {31'd0, bus.iwait}, 1);
    chk("rst_dwait", {31'd0, bus.dwait}, 1);
    chk("rst_ramren", {31'd0, bus.ramREN}, 0);
    chk("rst_ramwen", {31'd0, bus.ramWEN}, 0);
    chk("rst_memerr", {31'd0, bus.memerr}, 0);
    repeat (2) @(posedge clk);
    #1 bus.nRST = 1'b1;

    // Single instruction read, ACCESS on second grant cycle
    ram_lat = 2; c0 = cyc;
    issue_i(32'h40);
    wait_side(0, 20, cd);
    chk("i_latency", cd - c0, 3);
    step();
    chk("i_after_iwait", {31'd0, bus.iwait}, 1);
    chk("i_after_ramren", {31'd0, bus.ramREN}, 0);
    adv();

    // Simultaneous instruction read and data write: data first, one IDLE gap
    ram_lat = 1; order.delete();
    issue_i(32'h44);
    issue_dw(32'h100, 32'h1234, 1'b0);
    wait_side(1, 20, cd);
    wait_side(0, 20, ci);
    chk("gap_d_to_i", ci - cd, 2);
    chk("simul_order_len", order.size(), 2);
    chk("simul_first_d", {31'd0, order[0]}, 1);

    // Continuous contention
    order.delete(); ram_lat = 1; k = 1;
    issue_i(32'h1000); issue_dr(32'h2000);
    for (int n = 0; n < 200; n++) begin
      cycle();
      if (order.size() >= 6) break;
      if (!bus.iREN) issue_i(32'h1000 + k * 4);
      if (!bus.dREN) issue_dr(32'h2000 + k * 4);
      k++;
    end
    for (int n = 0; n < 50; n++) begin
      if (!bus.iREN && !bus.dREN && !bus.dWEN) break;
      cycle();
    end
`ifdef MEM_ARB_FAIR_EN
    exp_ord = '{1, 0, 1, 0, 1, 0, 1};
`else
    exp_ord = '{1, 1, 1, 1, 1, 1, 0};
`endif
    chk("order_len", order.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < order.size()) chk($sformatf("order_%0d", i), {31'd0, order[i]}, exp_ord[i]);
    end

    // Write with dREN also high must still be a write
    ram_lat = 2; c0 = cyc;
    issue_dw(32'h120, 32'h55AA, 1'b1);
    wait_side(1, 20, cd);
    chk("dw_latency", cd - c0, 3);

    // Data read, slower RAM
    ram_lat = 3; c0 = cyc;
    issue_dr(32'h180);
    wait_side(1, 20, cd);
    chk("dr_latency", cd - c0, 4);

    // Watchdog: RAM stuck BUSY
    ram_lat = 0; c0 = cyc; m0 = merr_cnt; found = 0;
    issue_dw(32'h200, 32'hBEEF, 1'b0);
    for (int n = 0; n < 100; n++) begin
      step();
      if (merr_cnt != m0) begin found = 1; break; end
      adv();
    end
    chk("wd_fired", {31'd0, found}, 1);
    chk("wd_cycle", merr_cyc - c0, 65);
    chk("wd_dwait", {31'd0, bus.dwait}, 1);
    adv();
    step();
    chk("wd_idle_wen", {31'd0, bus.ramWEN}, 0);
    chk("wd_idle_dwait", {31'd0, bus.dwait}, 1);
    adv();
    bus.dWEN = 1'b0;
    step();
    chk("drop_wen", {31'd0, bus.ramWEN}, 0);
    chk("drop_dwait", {31'd0, bus.dwait}, 1);
    adv();
    void'(dq.pop_front());
    void'(wq.pop_front());
    exp_merr++;

    // RAM reports ERROR
    ram_err = 1; ram_lat = 1; c0 = cyc; m0 = merr_cnt; found = 0;
    issue_i(32'h80);
    for (int n = 0; n < 10; n++) begin
      step();
      if (merr_cnt != m0) begin found = 1; break; end
      adv();
    end
    chk("err_fired", {31'd0, found}, 1);
    chk("err_cycle", merr_cyc - c0, 2);
    chk("err_iwait", {31'd0, bus.iwait}, 1);
    adv();
    bus.iREN = 1'b0; ram_err = 0;
    void'(iq.pop_front());
    exp_merr++;
    cycle();

    // Reset during a data write grant, instruction read pending
    ram_lat = 0;
    issue_dw(32'h300, 32'h77, 1'b0);
    cycle();
    cycle();
    issue_i(32'h500);
    step();
    chk("pre_rst_wen", {31'd0, bus.ramWEN}, 1);
    #1 bus.nRST = 1'b0;
    bus.dWEN = 1'b0;
    #1;
    chk("mrst_wen", {31'd0, bus.ramWEN}, 0);
    chk("mrst_ren", {31'd0, bus.ramREN}, 0);
    chk("mrst_dwait", {31'd0, bus.dwait}, 1);
    chk("mrst_iwait", {31'd0, bus.iwait}, 1);
    chk("mrst_memerr", {31'd0, bus.memerr}, 0);
    @(posedge clk);
    #1 bus.nRST = 1'b1;
    void'(dq.pop_front());
    void'(wq.pop_front());
    ram_lat = 1; c0 = cyc;
    wait_side(0, 20, ci);
    chk("post_rst_latency", ci - c0, 2);
    cycle();

    chk("memerr_total", merr_cnt, exp_merr);
    chk("iq_left", iq.size(), 0);
    chk("dq_left", dq.size(), 0);
    chk("wq_left", wq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
